// File: rtl/sdram_cmd_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller command port between two requesters.
// Read tags are queued so that returned data is routed back to the port that issued the read.
module sdram_cmd_arbiter #(
  parameter int unsigned AddrWidth = 23,
  parameter int unsigned DataWidth = 16,
  parameter int unsigned TagDepth  = 4
) (
  input  logic                 clk12mhz,
  input  logic                 rst,
  input  logic                 p0_trigger,
  input  logic                 p0_write,
  input  logic [AddrWidth-1:0] p0_addr,
  input  logic [DataWidth-1:0] p0_wdata,
  output logic                 p0_ready,
  output logic [DataWidth-1:0] p0_rdata,
  output logic                 p0_rvalid,
  input  logic                 p1_trigger,
  input  logic                 p1_write,
  input  logic [AddrWidth-1:0] p1_addr,
  input  logic [DataWidth-1:0] p1_wdata,
  output logic                 p1_ready,
  output logic [DataWidth-1:0] p1_rdata,
  output logic                 p1_rvalid,
  input  logic                 ctrl_ready,
  output logic                 ctrl_trigger,
  output logic                 ctrl_write,
  output logic [AddrWidth-1:0] ctrl_addr,
  output logic [DataWidth-1:0] ctrl_wdata,
  input  logic [DataWidth-1:0] ctrl_rdata,
  input  logic                 ctrl_rvalid,
  output logic                 err_spurious
);

  localparam int unsigned PtrW = $clog2(TagDepth);
  localparam logic [PtrW:0] TagFull = (PtrW + 1)'(TagDepth);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e              state_q;
  logic                grant_q;
  logic                last_grant_q;
  logic [TagDepth-1:0] tag_mem_q;
  logic [PtrW-1:0]     wr_ptr_q;
  logic [PtrW-1:0]     rd_ptr_q;
  logic [PtrW:0]       tag_count_q;

  logic acc, tag_full, tag_empty, elig0, elig1, pick, push, pop;

  assign acc       = ctrl_trigger & ctrl_ready;
  assign p0_ready  = acc & ~grant_q;
  assign p1_ready  = acc & grant_q;
  assign tag_full  = (tag_count_q == TagFull);
  assign tag_empty = (tag_count_q == '0);

  // Reads need a free tag slot; writes never return data, so they bypass the full check.
  assign elig0 = p0_trigger & (p0_write | ~tag_full);
  assign elig1 = p1_trigger & (p1_write | ~tag_full);
  assign pick  = (elig0 & elig1) ? ~last_grant_q : elig1;

  assign push = (state_q == StIssue) & acc & ~ctrl_write;
  assign pop  = ctrl_rvalid & ~tag_empty;

  always_ff @(posedge clk12mhz) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ctrl_trigger <= 1'b0;
      ctrl_write   <= 1'b0;
      ctrl_addr    <= '0;
      ctrl_wdata   <= '0;
      tag_mem_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tag_count_q  <= '0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
      p0_rvalid    <= 1'b0;
      p1_rvalid    <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (elig0 | elig1) begin
            grant_q      <= pick;
            ctrl_write   <= pick ? p1_write : p0_write;
            ctrl_addr    <= pick ? p1_addr : p0_addr;
            ctrl_wdata   <= pick ? p1_wdata : p0_wdata;
            ctrl_trigger <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          if (acc) begin
            ctrl_trigger <= 1'b0;
            last_grant_q <= grant_q;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (push) begin
        tag_mem_q[wr_ptr_q] <= grant_q;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end

      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        if (tag_mem_q[rd_ptr_q]) begin
          p1_rdata  <= ctrl_rdata;
          p1_rvalid <= 1'b1;
        end else begin
          p0_rdata  <= ctrl_rdata;
          p0_rvalid <= 1'b1;
        end
      end else if (ctrl_rvalid) begin
        err_spurious <= 1'b1;
      end

      case ({push, pop})
        2'b10:   tag_count_q <= tag_count_q + 1'b1;
        2'b01:   tag_count_q <= tag_count_q - 1'b1;
        default: tag_count_q <= tag_count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed bench for sdram_cmd_arbiter: drives on the falling edge, checks with immediate asserts.
module tb_sdram_cmd_arbiter;

  localparam int unsigned AW = 23;
  localparam int unsigned DW = 16;

  logic          clk12mhz = 1'b0;
  logic          rst;
  logic          p0_trigger, p0_write, p1_trigger, p1_write;
  logic [AW-1:0] p0_addr, p1_addr, ctrl_addr;
  logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, ctrl_wdata, ctrl_rdata;
  logic          p0_ready, p1_ready, p0_rvalid, p1_rvalid;
  logic          ctrl_ready, ctrl_trigger, ctrl_write, ctrl_rvalid, err_spurious;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk12mhz = ~clk12mhz;

  sdram_cmd_arbiter #(.AddrWidth(AW), .DataWidth(DW), .TagDepth(4)) dut (
    .clk12mhz    (clk12mhz),
    .rst         (rst),
    .p0_trigger  (p0_trigger),
    .p0_write    (p0_write),
    .p0_addr     (p0_addr),
    .p0_wdata    (p0_wdata),
    .p0_ready    (p0_ready),
    .p0_rdata    (p0_rdata),
    .p0_rvalid   (p0_rvalid),
    .p1_trigger  (p1_trigger),
    .p1_write    (p1_write),
    .p1_addr     (p1_addr),
    .p1_wdata    (p1_wdata),
    .p1_ready    (p1_ready),
    .p1_rdata    (p1_rdata),
    .p1_rvalid   (p1_rvalid),
    .ctrl_ready  (ctrl_ready),
    .ctrl_trigger(ctrl_trigger),
    .ctrl_write  (ctrl_write),
    .ctrl_addr   (ctrl_addr),
    .ctrl_wdata  (ctrl_wdata),
    .ctrl_rdata  (ctrl_rdata),
    .ctrl_rvalid (ctrl_rvalid),
    .err_spurious(err_spurious)
  );

  task automatic cyc();
    @(negedge clk12mhz);
    #1;
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    p0_trigger = 1'b0; p0_write = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_trigger = 1'b0; p1_write = 1'b0; p1_addr = '0; p1_wdata = '0;
    ctrl_ready = 1'b0; ctrl_rdata = '0; ctrl_rvalid = 1'b0;

    // Reset state
    cyc(); cyc();
    chk1("rst_trigger", ctrl_trigger, 1'b0);
    chk1("rst_p0_rvalid", p0_rvalid, 1'b0);
    chk1("rst_p1_rvalid", p1_rvalid, 1'b0);
    chk1("rst_err", err_spurious, 1'b0);
    chka("rst_addr", ctrl_addr, 23'h0);
    chkd("rst_p0_rdata", p0_rdata, 16'h0);

    // 1. Single write from p0
    rst = 1'b0;
    p0_trigger = 1'b1; p0_write = 1'b1; p0_addr = 23'h000123; p0_wdata = 16'hBEEF;
    ctrl_ready = 1'b1;
    #1;
    chk1("t1_ready_idle", p0_ready, 1'b0);
    cyc();
    chk1("t1_trigger", ctrl_trigger, 1'b1);
    chka("t1_addr", ctrl_addr, 23'h000123);
    chkd("t1_wdata", ctrl_wdata, 16'hBEEF);
    chk1("t1_write", ctrl_write, 1'b1);
    chk1("t1_p0_ready", p0_ready, 1'b1);
    chk1("t1_p1_ready", p1_ready, 1'b0);
    cyc();
    p0_trigger = 1'b0;
    chk1("t1_trigger_drop", ctrl_trigger, 1'b0);
    chk1("t1_ready_once", p0_ready, 1'b0);
    cyc();
    chk1("t1_idle", ctrl_trigger, 1'b0);

    // 2. Round-robin with both ports requesting continuously, starting from reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    p0_trigger = 1'b1; p0_write = 1'b1; p0_addr = 23'h000A00; p0_wdata = 16'h00A0;
    p1_trigger = 1'b1; p1_write = 1'b1; p1_addr = 23'h000B01; p1_wdata = 16'h00B1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk1("t2_trigger", ctrl_trigger, 1'b1);
      chka("t2_addr", ctrl_addr, (i % 2 == 0) ? 23'h000A00 : 23'h000B01);
      chk1("t2_p0_ready", p0_ready, (i % 2 == 0));
      chk1("t2_p1_ready", p1_ready, (i % 2 == 1));
      cyc();
      chk1("t2_gap", ctrl_trigger, 1'b0);
    end
    p0_trigger = 1'b0; p1_trigger = 1'b0;
    cyc();

    // 3. p1 read then p0 read; data routed back in order
    p1_trigger = 1'b1; p1_write = 1'b0; p1_addr = 23'h000010;
    cyc();
    chka("t3_addr_p1", ctrl_addr, 23'h000010);
    chk1("t3_read", ctrl_write, 1'b0);
    chk1("t3_p1_ready", p1_ready, 1'b1);
    cyc();
    p1_trigger = 1'b0;
    p0_trigger = 1'b1; p0_write = 1'b0; p0_addr = 23'h000020;
    cyc();
    chka("t3_addr_p0", ctrl_addr, 23'h000020);
    chk1("t3_p0_ready", p0_ready, 1'b1);
    cyc();
    p0_trigger = 1'b0;
    ctrl_rvalid = 1'b1; ctrl_rdata = 16'h1111;
    cyc();
    chk1("t3_p1_rvalid", p1_rvalid, 1'b1);
    chkd("t3_p1_rdata", p1_rdata, 16'h1111);
    chk1("t3_p0_rvalid_0", p0_rvalid, 1'b0);
    ctrl_rdata = 16'h2222;
    cyc();
    chk1("t3_p0_rvalid", p0_rvalid, 1'b1);
    chkd("t3_p0_rdata", p0_rdata, 16'h2222);
    chk1("t3_p1_rvalid_0", p1_rvalid, 1'b0);
    chkd("t3_p1_rdata_hold", p1_rdata, 16'h1111);
    ctrl_rvalid = 1'b0;
    cyc();
    chk1("t3_rvalid_pulse", p0_rvalid, 1'b0);
    chk1("t3_no_err", err_spurious, 1'b0);

    // 4. Fill the tag FIFO; a further read stalls while a write still proceeds
    p0_trigger = 1'b1; p0_write = 1'b0; p0_addr = 23'h000100;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk1("t4_fill_ready", p0_ready, 1'b1);
      chka("t4_fill_addr", ctrl_addr, 23'h000100 + 23'(i));
      cyc();
      p0_addr = 23'h000101 + 23'(i);
    end
    cyc();
    chk1("t4_full_trigger", ctrl_trigger, 1'b0);
    chk1("t4_full_ready", p0_ready, 1'b0);
    p1_trigger = 1'b1; p1_write = 1'b1; p1_addr = 23'h000200; p1_wdata = 16'h5A5A;
    cyc();
    chk1("t4_wr_trigger", ctrl_trigger, 1'b1);
    chka("t4_wr_addr", ctrl_addr, 23'h000200);
    chk1("t4_wr_p1_ready", p1_ready, 1'b1);
    chk1("t4_wr_p0_ready", p0_ready, 1'b0);
    cyc();
    p1_trigger = 1'b0;
    cyc();
    chk1("t4_still_held", ctrl_trigger, 1'b0);
    ctrl_rvalid = 1'b1; ctrl_rdata = 16'h3333;
    cyc();
    ctrl_rvalid = 1'b0;
    chk1("t4_free_rvalid", p0_rvalid, 1'b1);
    chkd("t4_free_rdata", p0_rdata, 16'h3333);
    chk1("t4_free_no_issue", ctrl_trigger, 1'b0);
    cyc();
    chk1("t4_late_trigger", ctrl_trigger, 1'b1);
    chka("t4_late_addr", ctrl_addr, 23'h000104);
    chk1("t4_late_ready", p0_ready, 1'b1);
    cyc();
    p0_trigger = 1'b0;
    ctrl_rvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ctrl_rdata = 16'h4000 + 16'(k);
      cyc();
      chk1("t4_drain_rvalid", p0_rvalid, 1'b1);
      chkd("t4_drain_rdata", p0_rdata, 16'h4000 + 16'(k));
      chk1("t4_drain_p1", p1_rvalid, 1'b0);
    end
    ctrl_rvalid = 1'b0;
    cyc();
    chk1("t4_drained_err", err_spurious, 1'b0);

    // 5. Spurious return with an empty FIFO
    ctrl_rvalid = 1'b1; ctrl_rdata = 16'hDEAD;
    cyc();
    ctrl_rvalid = 1'b0;
    chk1("t5_p0_rvalid", p0_rvalid, 1'b0);
    chk1("t5_p1_rvalid", p1_rvalid, 1'b0);
    chk1("t5_err", err_spurious, 1'b1);
    chkd("t5_p0_rdata", p0_rdata, 16'h4003);
    cyc(); cyc();
    chk1("t5_err_sticky", err_spurious, 1'b1);

    // 6. Reset during ISSUE with two reads outstanding
    p0_trigger = 1'b1; p0_write = 1'b0; p0_addr = 23'h000300;
    cyc(); cyc();
    p0_addr = 23'h000301;
    cyc(); cyc();
    p0_addr = 23'h000302;
    ctrl_ready = 1'b0;
    cyc();
    chk1("t6_issue", ctrl_trigger, 1'b1);
    chk1("t6_no_ready", p0_ready, 1'b0);
    rst = 1'b1; p0_trigger = 1'b0;
    cyc();
    rst = 1'b0;
    chk1("t6_rst_trigger", ctrl_trigger, 1'b0);
    chk1("t6_rst_err", err_spurious, 1'b0);
    chka("t6_rst_addr", ctrl_addr, 23'h0);
    p0_trigger = 1'b1; p0_write = 1'b0; p0_addr = 23'h000400; ctrl_ready = 1'b1;
    cyc();
    chk1("t6_new_trigger", ctrl_trigger, 1'b1);
    chka("t6_new_addr", ctrl_addr, 23'h000400);
    chk1("t6_new_ready", p0_ready, 1'b1);
    cyc();
    p0_trigger = 1'b0;
    ctrl_rvalid = 1'b1; ctrl_rdata = 16'h6666;
    cyc();
    chk1("t6_ret_rvalid", p0_rvalid, 1'b1);
    chkd("t6_ret_rdata", p0_rdata, 16'h6666);
    chk1("t6_ret_no_err", err_spurious, 1'b0);
    // Old tags were discarded, so a second return has nothing to match
    cyc();
    ctrl_rvalid = 1'b0;
    chk1("t6_second_rvalid", p0_rvalid, 1'b0);
    chk1("t6_fifo_empty", err_spurious, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
